ddr3_arbiter: RTL and testbench
===============================

# ddr3_arbiter

Two-requester arbiter that shares the single Avalon-MM port of `ddr3_controller` between a primary requester (m0, the CPU core) and a secondary requester (m1, e.g. a DMA or display engine). It uses round-robin arbitration into a one-entry registered command stage that holds the command stable under `avl_ready` backpressure. An in-order tag FIFO routes each read response back to its issuer. It sits between the requesters and `ddr3_controller`, in the `clk` (afi_clk) domain.

## Interface
- `DATA_WIDTH`, 64: data bus width; `BE_WIDTH = DATA_WIDTH/8`.
- `ADDR_WIDTH`, 24: word address width.
- `TAG_DEPTH`, 8: maximum outstanding reads; power of two, ≥2.

Ports:
- `clk`  in  1  clock
- `reset`  in  1  asynchronous, active-high
- `mN_read_req`, `mN_write_req`  in  1  request strobes (N = 0, 1)
- `mN_addr`  in  ADDR_WIDTH; `mN_wdata`  in  DATA_WIDTH; `mN_be`  in  BE_WIDTH
- `mN_ready`  out  1  request accepted this cycle
- `mN_rdata_valid`  out  1  read data for requester N
- `rdata`  out  DATA_WIDTH  read data, shared by both requesters
- `avl_ready`  in  1; `avl_rdata_valid`  in  1; `avl_rdata`  in  DATA_WIDTH
- `avl_burstbegin`, `avl_read_req`, `avl_write_req`  out  1
- `avl_addr`  out  ADDR_WIDTH; `avl_wdata`  out  DATA_WIDTH; `avl_be`  out  BE_WIDTH; `avl_size`  out  7
- `rsp_error`  out  1  sticky: response arrived with no outstanding read

## Operation
- Requester handshake: hold `req`/`addr`/`wdata`/`be` stable until `mN_ready`=1. Transfer occurs on the cycle `mN_ready`=1.
- Read and write asserted together: treated as a write.
- Command register: holds valid, type, addr, wdata, be.
  - `avl_read_req`/`avl_write_req` = valid && type.
  - `avl_burstbegin` = valid.
  - `avl_size` constant 1.
- Load condition: `load = (!valid || avl_ready) && winner_exists`.
  - If `load`=0 and `avl_ready`=1, valid clears.
- Eligibility:
  - Writes are always eligible.
  - Reads are eligible only if `outstanding < TAG_DEPTH`.
  - `outstanding` = FIFO occupancy + (1 if the register holds a read).
  - A same-cycle pop does not free a slot for a same-cycle load.
- Round-robin:
  - 1-bit `prio` pointer, reset to m0.
  - If both requesters are eligible, `prio` wins.
  - After any grant, `prio` points to the non-granted requester.
  - A single eligible requester wins regardless of `prio`.
- `mN_ready = load && grant == N` (combinational from requests, `avl_ready` and state).
- Tag FIFO:
  - Push the requester ID when a read leaves the register (valid && read && `avl_ready`).
  - Pop on `avl_rdata_valid`.
  - Simultaneous push and pop is legal; occupancy is unchanged.
- Response routing: on `avl_rdata_valid` with FIFO non-empty:
  - Next cycle, `rdata` = `avl_rdata`.
  - `m[head]_rdata_valid` = 1 for one cycle.
- `avl_rdata_valid` with FIFO empty: response dropped, `rsp_error` set. Cleared only by reset.
- Reset values: all `avl_*` request outputs, `mN_rdata_valid`, `rsp_error` = 0; `rdata`, addr, data = 0; FIFO empty; `prio` = m0.
- Reset mid-operation: in-flight command and tags are discarded. Responses arriving after reset are dropped and flagged as `rsp_error`.

## Timing
- Request to `avl_*`: accepted at cycle t, driven on `avl_*` at t+1.
- `avl_ready` low: command held bit-stable on `avl_*` until the cycle `avl_ready`=1.
- Back-to-back: with `avl_ready` held high, one command per cycle.
- Response: `avl_rdata_valid` at cycle u → `mN_rdata_valid` and `rdata` at u+1.
- Response order equals issue order across both requesters.

## Structure
- `ddr3_arbiter_pkg`:
  - `requester_id_t` (1 bit).
  - Avalon width constants (`AVL_ADDR_WIDTH` = 24, `AVL_SIZE_WIDTH` = 7).
  - `AVL_SIZE_SINGLE` = 7'd1.
- Sub-module `ddr3_arbiter_tag_fifo`:
  - Synchronous FIFO of `requester_id_t`, depth `TAG_DEPTH`.
  - Ports: push, pop, head, count, empty, full; asynchronous reset.

## Test plan
- Single m0 read to addr 0x000123, `avl_ready`=1, response 3 cycles after issue with data 0xDEADBEEF_CAFEF00D:
  - `m0_ready` at t; `avl_read_req`, `avl_addr`=0x000123 at t+1.
  - `m0_rdata_valid`, `rdata` = data one cycle after `avl_rdata_valid`; `m1_rdata_valid` stays 0.
- m0 and m1 both issue continuous writes: grants alternate m0, m1, m0, m1.
- `avl_ready` held 0 for 5 cycles with a write pending:
  - `avl_*` stable throughout; both `mN_ready`=0.
  - Accepted on the cycle `avl_ready` rises.
- `TAG_DEPTH`=4, m1 issues 6 reads with no responses:
  - Only 4 accepted.
  - Concurrent m0 writes still granted.
  - After 1 response, the 5th read is accepted.
- Interleaved reads m0, m1, m0 with in-order responses A, B, C: A→m0, B→m1, C→m0.
- `avl_rdata_valid` with no outstanding reads → `rsp_error`=1 and no `mN_rdata_valid`. After reset mid-burst, all outputs return to reset values.

Source files
------------

// File: rtl/ddr3_arbiter_pkg.sv
// Shared types and Avalon-MM constants for the two-requester DDR3 arbiter.
// Requester IDs are one bit wide: m0 is the CPU core and m1 is the secondary engine.
package ddr3_arbiter_pkg;

  typedef logic requester_id_t;

  localparam requester_id_t REQ_M0 = 1'b0;
  localparam requester_id_t REQ_M1 = 1'b1;

  localparam int AVL_ADDR_WIDTH = 24;
  localparam int AVL_SIZE_WIDTH = 7;

  localparam logic [AVL_SIZE_WIDTH-1:0] AVL_SIZE_SINGLE = 7'd1;

endpackage

// File: rtl/ddr3_arbiter_tag_fifo.sv
// In-order FIFO of requester IDs for outstanding reads; head is valid while not empty.
// Push when full and pop when empty are ignored. A push and a pop in the same cycle leave the count unchanged.
module ddr3_arbiter_tag_fifo
  import ddr3_arbiter_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push_i,
  input  requester_id_t          push_id_i,
  input  logic                   pop_i,
  output requester_id_t          head_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   empty_o,
  output logic                   full_o
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_CNT = DEPTH[PW:0];

  requester_id_t   mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q;
  logic [PW-1:0]   rd_ptr_q;
  logic [PW:0]     count_q;
  logic            do_push;
  logic            do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == DEPTH_CNT);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: entries are only read between a push and its pop.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_id_i;
  end

endmodule

// File: rtl/ddr3_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM port between m0 and m1. A request is accepted at t and appears on avl_* at t+1.
// The command is held bit-stable while avl_ready is low. Read data returns to its issuer one cycle after avl_rdata_valid.
module ddr3_arbiter
  import ddr3_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int BE_WIDTH   = DATA_WIDTH / 8,
  parameter int ADDR_WIDTH = AVL_ADDR_WIDTH,
  parameter int TAG_DEPTH  = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      m0_read_req,
  input  logic                      m0_write_req,
  input  logic [ADDR_WIDTH-1:0]     m0_addr,
  input  logic [DATA_WIDTH-1:0]     m0_wdata,
  input  logic [BE_WIDTH-1:0]       m0_be,
  output logic                      m0_ready,
  output logic                      m0_rdata_valid,
  input  logic                      m1_read_req,
  input  logic                      m1_write_req,
  input  logic [ADDR_WIDTH-1:0]     m1_addr,
  input  logic [DATA_WIDTH-1:0]     m1_wdata,
  input  logic [BE_WIDTH-1:0]       m1_be,
  output logic                      m1_ready,
  output logic                      m1_rdata_valid,
  output logic [DATA_WIDTH-1:0]     rdata,
  input  logic                      avl_ready,
  input  logic                      avl_rdata_valid,
  input  logic [DATA_WIDTH-1:0]     avl_rdata,
  output logic                      avl_burstbegin,
  output logic                      avl_read_req,
  output logic                      avl_write_req,
  output logic [ADDR_WIDTH-1:0]     avl_addr,
  output logic [DATA_WIDTH-1:0]     avl_wdata,
  output logic [BE_WIDTH-1:0]       avl_be,
  output logic [AVL_SIZE_WIDTH-1:0] avl_size,
  output logic                      rsp_error
);

  localparam int CW = $clog2(TAG_DEPTH) + 1;
  localparam logic [CW:0] TAG_LIMIT = TAG_DEPTH[CW:0];

  logic                  cmd_vld_q, cmd_vld_d;
  logic                  cmd_wr_q, cmd_wr_d;
  requester_id_t         cmd_src_q, cmd_src_d;
  logic [ADDR_WIDTH-1:0] cmd_addr_q, cmd_addr_d;
  logic [DATA_WIDTH-1:0] cmd_wdata_q, cmd_wdata_d;
  logic [BE_WIDTH-1:0]   cmd_be_q, cmd_be_d;
  requester_id_t         prio_q, prio_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  rvld0_q, rvld0_d;
  logic                  rvld1_q, rvld1_d;
  logic                  err_q, err_d;

  logic [CW-1:0]  tag_count;
  logic           tag_empty, tag_full;
  requester_id_t  tag_head;
  logic [CW:0]    reg_read, outstanding;
  logic           read_ok, elig0, elig1, load, tag_push, tag_pop;
  requester_id_t  grant;

  // The read sitting in the command register already owns a tag slot.
  assign reg_read    = {{CW{1'b0}}, cmd_vld_q && !cmd_wr_q};
  assign outstanding = {1'b0, tag_count} + reg_read;
  assign read_ok     = !tag_full && (outstanding < TAG_LIMIT);

  assign elig0 = m0_write_req || (m0_read_req && read_ok);
  assign elig1 = m1_write_req || (m1_read_req && read_ok);
  assign grant = (elig0 && elig1) ? prio_q : (elig1 ? REQ_M1 : REQ_M0);
  assign load  = (!cmd_vld_q || avl_ready) && (elig0 || elig1);

  assign m0_ready = load && (grant == REQ_M0);
  assign m1_ready = load && (grant == REQ_M1);

  assign tag_push = cmd_vld_q && !cmd_wr_q && avl_ready;
  assign tag_pop  = avl_rdata_valid && !tag_empty;

  always_comb begin
    cmd_vld_d   = cmd_vld_q;
    cmd_wr_d    = cmd_wr_q;
    cmd_src_d   = cmd_src_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    cmd_be_d    = cmd_be_q;
    prio_d      = prio_q;
    if (load) begin
      cmd_vld_d   = 1'b1;
      cmd_src_d   = grant;
      cmd_wr_d    = (grant == REQ_M1) ? m1_write_req : m0_write_req;
      cmd_addr_d  = (grant == REQ_M1) ? m1_addr      : m0_addr;
      cmd_wdata_d = (grant == REQ_M1) ? m1_wdata     : m0_wdata;
      cmd_be_d    = (grant == REQ_M1) ? m1_be        : m0_be;
      prio_d      = ~grant;
    end else if (avl_ready) begin
      cmd_vld_d = 1'b0;
    end
  end

  always_comb begin
    rdata_d = tag_pop ? avl_rdata : rdata_q;
    rvld0_d = tag_pop && (tag_head == REQ_M0);
    rvld1_d = tag_pop && (tag_head == REQ_M1);
    err_d   = err_q || (avl_rdata_valid && tag_empty);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_vld_q   <= 1'b0;
      cmd_wr_q    <= 1'b0;
      cmd_src_q   <= REQ_M0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      cmd_be_q    <= '0;
      prio_q      <= REQ_M0;
      rdata_q     <= '0;
      rvld0_q     <= 1'b0;
      rvld1_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      cmd_vld_q   <= cmd_vld_d;
      cmd_wr_q    <= cmd_wr_d;
      cmd_src_q   <= cmd_src_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      cmd_be_q    <= cmd_be_d;
      prio_q      <= prio_d;
      rdata_q     <= rdata_d;
      rvld0_q     <= rvld0_d;
      rvld1_q     <= rvld1_d;
      err_q       <= err_d;
    end
  end

  ddr3_arbiter_tag_fifo #(.DEPTH(TAG_DEPTH)) u_tag_fifo (
    .clk       (clk),
    .reset     (reset),
    .push_i    (tag_push),
    .push_id_i (cmd_src_q),
    .pop_i     (tag_pop),
    .head_o    (tag_head),
    .count_o   (tag_count),
    .empty_o   (tag_empty),
    .full_o    (tag_full)
  );

  assign avl_burstbegin = cmd_vld_q;
  assign avl_read_req   = cmd_vld_q && !cmd_wr_q;
  assign avl_write_req  = cmd_vld_q && cmd_wr_q;
  assign avl_addr       = cmd_addr_q;
  assign avl_wdata      = cmd_wdata_q;
  assign avl_be         = cmd_be_q;
  assign avl_size       = AVL_SIZE_SINGLE;
  assign rdata          = rdata_q;
  assign m0_rdata_valid = rvld0_q;
  assign m1_rdata_valid = rvld1_q;
  assign rsp_error      = err_q;

endmodule

// File: tb/tb_ddr3_arbiter.sv
// Bench for ddr3_arbiter with TAG_DEPTH=4: vector table, directed corner sequences, and a
// randomized run compared against a queue-based reference model of the arbitration rules.
module tb_ddr3_arbiter;

  localparam int DW = 64;
  localparam int BW = 8;
  localparam int AW = 24;
  localparam int TD = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          m0_read_req, m0_write_req, m1_read_req, m1_write_req;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic [BW-1:0] m0_be, m1_be;
  logic          m0_ready, m1_ready, m0_rdata_valid, m1_rdata_valid;
  logic [DW-1:0] rdata;
  logic          avl_ready, avl_rdata_valid;
  logic [DW-1:0] avl_rdata;
  logic          avl_burstbegin, avl_read_req, avl_write_req;
  logic [AW-1:0] avl_addr;
  logic [DW-1:0] avl_wdata;
  logic [BW-1:0] avl_be;
  logic [6:0]    avl_size;
  logic          rsp_error;

  always #5 clk = ~clk;

  ddr3_arbiter #(.DATA_WIDTH(DW), .BE_WIDTH(BW), .ADDR_WIDTH(AW), .TAG_DEPTH(TD)) dut (
    .clk(clk), .reset(reset),
    .m0_read_req(m0_read_req), .m0_write_req(m0_write_req), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_be(m0_be), .m0_ready(m0_ready), .m0_rdata_valid(m0_rdata_valid),
    .m1_read_req(m1_read_req), .m1_write_req(m1_write_req), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_be(m1_be), .m1_ready(m1_ready), .m1_rdata_valid(m1_rdata_valid),
    .rdata(rdata), .avl_ready(avl_ready), .avl_rdata_valid(avl_rdata_valid), .avl_rdata(avl_rdata),
    .avl_burstbegin(avl_burstbegin), .avl_read_req(avl_read_req), .avl_write_req(avl_write_req),
    .avl_addr(avl_addr), .avl_wdata(avl_wdata), .avl_be(avl_be), .avl_size(avl_size),
    .rsp_error(rsp_error)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    m0_read_req = 0; m0_write_req = 0; m1_read_req = 0; m1_write_req = 0;
    m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0; m0_be = '0; m1_be = '0;
    avl_ready = 1; avl_rdata_valid = 0; avl_rdata = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    repeat (2) @(posedge clk);
    #1 reset = 0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk($sformatf("%s avl_read_req", tag), avl_read_req, 0);
    chk($sformatf("%s avl_write_req", tag), avl_write_req, 0);
    chk($sformatf("%s avl_burstbegin", tag), avl_burstbegin, 0);
    chk($sformatf("%s avl_addr", tag), avl_addr, 0);
    chk($sformatf("%s avl_wdata", tag), avl_wdata, 0);
    chk($sformatf("%s avl_be", tag), avl_be, 0);
    chk($sformatf("%s m0_rdata_valid", tag), m0_rdata_valid, 0);
    chk($sformatf("%s m1_rdata_valid", tag), m1_rdata_valid, 0);
    chk($sformatf("%s rdata", tag), rdata, 0);
    chk($sformatf("%s rsp_error", tag), rsp_error, 0);
  endtask

  typedef struct packed {
    logic m0r, m0w, m1r, m1w, ardy;
    logic r0, r1, erd, ewr, esrc;
  } vec_t;
  vec_t vecs[7];

  typedef struct packed {
    logic          wr;
    logic          src;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [BW-1:0] be;
  } cmd_t;

  // reference model state
  cmd_t          slot[$];
  bit            tags[$];
  bit            prio_m, exp_rv0, exp_rv1, exp_err, ok_rd, ld, g, h, rsp;
  logic [DW-1:0] exp_rdata;
  bit            p_act[2], p_rd[2], p_wr[2], el[2];
  logic [AW-1:0] p_addr[2];
  logic [DW-1:0] p_wdata[2];
  logic [BW-1:0] p_be[2];
  int            outst, acc0, acc1, kind;

  initial begin
    reset = 1;
    idle();

    do_reset();
    chk("reset avl_size", avl_size, 7'd1);
    chk_reset_state("reset");

    //          m0r m0w m1r m1w rdy  r0 r1 rd wr src
    vecs[0] = '{1, 0, 0, 0, 1,   1, 0, 1, 0, 0};
    vecs[1] = '{0, 0, 0, 1, 1,   0, 1, 0, 1, 1};
    vecs[2] = '{0, 1, 0, 1, 1,   1, 0, 0, 1, 0};
    vecs[3] = '{1, 1, 0, 0, 1,   1, 0, 0, 1, 0};
    vecs[4] = '{0, 0, 0, 0, 1,   0, 0, 0, 0, 0};
    vecs[5] = '{1, 0, 1, 0, 0,   1, 0, 1, 0, 0};
    vecs[6] = '{0, 1, 1, 0, 1,   1, 0, 0, 1, 0};
    for (int i = 0; i < 7; i++) begin
      do_reset();
      m0_read_req = vecs[i].m0r; m0_write_req = vecs[i].m0w;
      m1_read_req = vecs[i].m1r; m1_write_req = vecs[i].m1w;
      avl_ready = vecs[i].ardy;
      m0_addr = 24'h000A00; m1_addr = 24'h000B11;
      m0_be = 8'h0F; m1_be = 8'hF0;
      #1;
      chk($sformatf("vec%0d m0_ready", i), m0_ready, vecs[i].r0);
      chk($sformatf("vec%0d m1_ready", i), m1_ready, vecs[i].r1);
      step();
      idle();
      #1;
      chk($sformatf("vec%0d avl_read_req", i), avl_read_req, vecs[i].erd);
      chk($sformatf("vec%0d avl_write_req", i), avl_write_req, vecs[i].ewr);
      chk($sformatf("vec%0d avl_burstbegin", i), avl_burstbegin, vecs[i].erd | vecs[i].ewr);
      if (vecs[i].erd | vecs[i].ewr) begin
        chk($sformatf("vec%0d avl_addr", i), avl_addr, vecs[i].esrc ? 24'h000B11 : 24'h000A00);
        chk($sformatf("vec%0d avl_be", i), avl_be, vecs[i].esrc ? 8'hF0 : 8'h0F);
      end
    end

    // single m0 read, response 3 cycles after issue
    do_reset();
    m0_read_req = 1; m0_addr = 24'h000123;
    #1;
    chk("single m0_ready", m0_ready, 1);
    chk("single m1_ready", m1_ready, 0);
    step(); m0_read_req = 0; #1;
    chk("single avl_read_req", avl_read_req, 1);
    chk("single avl_addr", avl_addr, 24'h000123);
    chk("single avl_write_req", avl_write_req, 0);
    step(); step(); step();
    avl_rdata_valid = 1; avl_rdata = 64'hDEADBEEF_CAFEF00D; #1;
    chk("single early m0_rdata_valid", m0_rdata_valid, 0);
    step(); avl_rdata_valid = 0; #1;
    chk("single m0_rdata_valid", m0_rdata_valid, 1);
    chk("single rdata", rdata, 64'hDEADBEEF_CAFEF00D);
    chk("single m1_rdata_valid", m1_rdata_valid, 0);
    step(); #1;
    chk("single m0_rdata_valid pulse", m0_rdata_valid, 0);

    // continuous writes from both: grants alternate starting at m0
    do_reset();
    m0_write_req = 1; m1_write_req = 1; m0_addr = 24'h10; m1_addr = 24'h20;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("alt%0d m0_ready", i), m0_ready, (i % 2) == 0);
      chk($sformatf("alt%0d m1_ready", i), m1_ready, (i % 2) == 1);
      step();
    end

    // write held under avl_ready=0 for 5 cycles
    do_reset();
    m0_write_req = 1; m0_addr = 24'h000055; m0_wdata = 64'h1122334455667788; m0_be = 8'hA5;
    #1;
    chk("stall load m0_ready", m0_ready, 1);
    step();
    m0_write_req = 0; m1_write_req = 1; m1_addr = 24'h000066; m1_wdata = 64'h99; m1_be = 8'hFF;
    avl_ready = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("stall%0d avl_write_req", i), avl_write_req, 1);
      chk($sformatf("stall%0d avl_addr", i), avl_addr, 24'h000055);
      chk($sformatf("stall%0d avl_wdata", i), avl_wdata, 64'h1122334455667788);
      chk($sformatf("stall%0d avl_be", i), avl_be, 8'hA5);
      chk($sformatf("stall%0d m0_ready", i), m0_ready, 0);
      chk($sformatf("stall%0d m1_ready", i), m1_ready, 0);
      step();
    end
    avl_ready = 1; #1;
    chk("stall release m1_ready", m1_ready, 1);
    chk("stall release avl_addr", avl_addr, 24'h000055);
    step(); m1_write_req = 0; #1;
    chk("stall next avl_addr", avl_addr, 24'h000066);

    // read-slot limit with TAG_DEPTH=4
    do_reset();
    acc0 = 0; acc1 = 0;
    m1_read_req = 1; m1_addr = 24'h000100; m0_write_req = 1; m0_addr = 24'h000200;
    for (int i = 0; i < 14; i++) begin
      #1;
      if (m1_ready) begin acc1++; m1_addr = m1_addr + 1; end
      if (m0_ready) acc0++;
      step();
    end
    chk("limit reads accepted", acc1, 4);
    chk("limit writes granted", acc0 >= 4, 1);
    m0_write_req = 0;
    step(); step();
    avl_rdata_valid = 1; avl_rdata = 64'h5;
    step(); avl_rdata_valid = 0; #1;
    chk("limit m1_rdata_valid", m1_rdata_valid, 1);
    for (int i = 0; i < 6; i++) begin
      if (m1_ready) begin acc1++; m1_addr = m1_addr + 1; end
      step(); #1;
    end
    chk("limit fifth read", acc1, 5);

    // interleaved reads m0, m1, m0 with in-order responses
    do_reset();
    m0_read_req = 1; m0_addr = 24'h1; #1;
    chk("ilv m0_ready a", m0_ready, 1);
    step(); m0_read_req = 0; m1_read_req = 1; m1_addr = 24'h2; #1;
    chk("ilv m1_ready", m1_ready, 1);
    step(); m1_read_req = 0; m0_read_req = 1; m0_addr = 24'h3; #1;
    chk("ilv m0_ready c", m0_ready, 1);
    step(); m0_read_req = 0;
    step(); step();
    avl_rdata_valid = 1; avl_rdata = 64'hAAAA; step();
    avl_rdata = 64'hBBBB; #1;
    chk("ilv A m0_rdata_valid", m0_rdata_valid, 1);
    chk("ilv A m1_rdata_valid", m1_rdata_valid, 0);
    chk("ilv A rdata", rdata, 64'hAAAA);
    step(); avl_rdata = 64'hCCCC; #1;
    chk("ilv B m1_rdata_valid", m1_rdata_valid, 1);
    chk("ilv B m0_rdata_valid", m0_rdata_valid, 0);
    chk("ilv B rdata", rdata, 64'hBBBB);
    step(); avl_rdata_valid = 0; #1;
    chk("ilv C m0_rdata_valid", m0_rdata_valid, 1);
    chk("ilv C rdata", rdata, 64'hCCCC);

    // orphan response, then reset in the middle of traffic
    do_reset();
    avl_rdata_valid = 1; avl_rdata = 64'h77; step();
    avl_rdata_valid = 0; #1;
    chk("orphan rsp_error", rsp_error, 1);
    chk("orphan m0_rdata_valid", m0_rdata_valid, 0);
    chk("orphan m1_rdata_valid", m1_rdata_valid, 0);
    step(); #1;
    chk("orphan rsp_error sticky", rsp_error, 1);
    m0_read_req = 1; m0_addr = 24'h7; step();
    m0_read_req = 0; m1_write_req = 1; m1_addr = 24'h8; m1_wdata = 64'h42; m1_be = 8'h3; step(); step();
    avl_rdata_valid = 1; avl_rdata = 64'h1234; step();
    avl_rdata_valid = 0; m0_read_req = 1; m0_addr = 24'h9; #1;
    chk("midrst pre m0_rdata_valid", m0_rdata_valid, 1);
    reset = 1; #1;
    chk_reset_state("midrst async");
    step(); idle(); step();
    reset = 0; #1;
    chk_reset_state("midrst after");
    avl_rdata_valid = 1; avl_rdata = 64'h55; step();
    avl_rdata_valid = 0; #1;
    chk("post-reset rsp_error", rsp_error, 1);
    chk("post-reset m0_rdata_valid", m0_rdata_valid, 0);

    // randomized run against the reference model
    do_reset();
    slot.delete(); tags.delete();
    prio_m = 0; exp_rv0 = 0; exp_rv1 = 0; exp_err = 0; exp_rdata = '0;
    p_act[0] = 0; p_act[1] = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int n = 0; n < 2; n++) begin
        if (!p_act[n] && $urandom_range(0, 2) == 0) begin
          kind = $urandom_range(0, 4);
          p_act[n]   = 1;
          p_rd[n]    = (kind <= 1) || (kind == 4);
          p_wr[n]    = (kind >= 2);
          p_addr[n]  = AW'($urandom);
          p_wdata[n] = {$urandom, $urandom};
          p_be[n]    = BW'($urandom);
        end
      end
      m0_read_req = p_act[0] && p_rd[0]; m0_write_req = p_act[0] && p_wr[0];
      m0_addr = p_addr[0]; m0_wdata = p_wdata[0]; m0_be = p_be[0];
      m1_read_req = p_act[1] && p_rd[1]; m1_write_req = p_act[1] && p_wr[1];
      m1_addr = p_addr[1]; m1_wdata = p_wdata[1]; m1_be = p_be[1];
      avl_ready = ($urandom_range(0, 3) != 0);
      rsp = (tags.size() > 0) && ($urandom_range(0, 2) == 0);
      avl_rdata_valid = rsp;
      avl_rdata = {$urandom, $urandom};
      #1;

      outst = tags.size() + ((slot.size() > 0 && !slot[0].wr) ? 1 : 0);
      ok_rd = outst < TD;
      for (int n = 0; n < 2; n++) el[n] = p_act[n] && (p_wr[n] || (p_rd[n] && ok_rd));
      g  = (el[0] && el[1]) ? prio_m : el[1];
      ld = (el[0] || el[1]) && (slot.size() == 0 || avl_ready);

      chk($sformatf("rnd%0d m0_ready", cyc), m0_ready, ld && !g);
      chk($sformatf("rnd%0d m1_ready", cyc), m1_ready, ld && g);
      chk($sformatf("rnd%0d avl_read_req", cyc), avl_read_req, slot.size() > 0 && !slot[0].wr);
      chk($sformatf("rnd%0d avl_write_req", cyc), avl_write_req, slot.size() > 0 && slot[0].wr);
      if (slot.size() > 0) begin
        chk($sformatf("rnd%0d avl_addr", cyc), avl_addr, slot[0].addr);
        chk($sformatf("rnd%0d avl_be", cyc), avl_be, slot[0].be);
        if (slot[0].wr) chk($sformatf("rnd%0d avl_wdata", cyc), avl_wdata, slot[0].wdata);
      end
      chk($sformatf("rnd%0d m0_rdata_valid", cyc), m0_rdata_valid, exp_rv0);
      chk($sformatf("rnd%0d m1_rdata_valid", cyc), m1_rdata_valid, exp_rv1);
      if (exp_rv0 || exp_rv1) chk($sformatf("rnd%0d rdata", cyc), rdata, exp_rdata);
      chk($sformatf("rnd%0d rsp_error", cyc), rsp_error, exp_err);

      exp_rv0 = 0; exp_rv1 = 0;
      if (rsp) begin
        if (tags.size() > 0) begin
          h = tags.pop_front();
          exp_rv0 = !h; exp_rv1 = h; exp_rdata = avl_rdata;
        end else begin
          exp_err = 1;
        end
      end
      if (slot.size() > 0 && avl_ready) begin
        if (!slot[0].wr) tags.push_back(slot[0].src);
        slot.delete();
      end
      if (ld) begin
        slot.push_back('{wr: p_wr[g], src: g, addr: p_addr[g], wdata: p_wdata[g], be: p_be[g]});
        prio_m = !g;
        p_act[g] = 0;
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
